// File: rtl/router_traffic_checker_if.sv
// Router FIFO-port bundle: the traffic checker drives the write side and drains
// the read side; the router (or a loopback model) sits on the slave modport.
interface router_traffic_checker_if #(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 8
);
  logic [N_CH-1:0]            wr;
  logic [N_CH*DATA_WIDTH-1:0] data;
  logic [N_CH-1:0]            full;
  logic [N_CH-1:0]            rd;
  logic [N_CH*DATA_WIDTH-1:0] q;
  logic [N_CH-1:0]            mty;

  modport master (output wr, data, rd, input full, q, mty);
  modport slave  (input wr, data, rd, output full, q, mty);
endinterface

// File: rtl/router_traffic_checker.sv
// Multi-channel router self-test: streams LFSR data into each router input FIFO,
// checks the matching output FIFO against a regenerated stream, flags errors/timeouts.
module router_traffic_checker #(
  parameter int          DATA_WIDTH = 8,
  parameter int          N_CH       = 4,
  parameter int          CNT_WIDTH  = 16,
  parameter int          TIMEOUT    = 1024,
  parameter logic [31:0] SEED       = 32'h0000_0001
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CNT_WIDTH-1:0]     num_words,
  input  logic [N_CH-1:0]          ch_en,
  router_traffic_checker_if.master rtr,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [N_CH-1:0]          timeout,
  output logic [N_CH-1:0]          err_ch,
  output logic [CNT_WIDTH-1:0]     err_cnt
);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int MIS_W  = $clog2(N_CH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] nw_q;
  logic [N_CH-1:0]      en_q;
  logic [31:0]          gen_lfsr [N_CH];
  logic [31:0]          exp_lfsr [N_CH];
  logic [CNT_WIDTH-1:0] sent     [N_CH];
  logic [CNT_WIDTH-1:0] issued   [N_CH];
  logic [CNT_WIDTH-1:0] recv     [N_CH];
  logic [IDLE_W-1:0]    idle_cnt [N_CH];
  logic [N_CH-1:0]      rd_d;

  logic [N_CH-1:0]            wr_c, rd_c, ch_fin, mism;
  logic [N_CH*DATA_WIDTH-1:0] data_c;
  logic [MIS_W-1:0]           n_mism;
  logic [CNT_WIDTH:0]         err_sum;

  function automatic logic [31:0] seed_of(input int ch);
    logic [31:0] s;
    s = SEED + 32'(ch);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  // Fibonacci, taps 32,22,2,1, shifting left with feedback into bit 0.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    wr_c   = '0;
    rd_c   = '0;
    ch_fin = '0;
    mism   = '0;
    data_c = '0;
    n_mism = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_c[i]   = (state == RUN) & en_q[i] & ~rtr.full[i] & (sent[i] < nw_q) & ~timeout[i];
      rd_c[i]   = (state == RUN) & en_q[i] & ~rtr.mty[i] & (issued[i] < nw_q) & ~timeout[i];
      ch_fin[i] = ~en_q[i] | (recv[i] == nw_q) | timeout[i];
      mism[i]   = rd_d[i] & (rtr.q[i*DATA_WIDTH +: DATA_WIDTH] != exp_lfsr[i][DATA_WIDTH-1:0]);
      if (state == RUN) data_c[i*DATA_WIDTH +: DATA_WIDTH] = gen_lfsr[i][DATA_WIDTH-1:0];
      n_mism = n_mism + MIS_W'(mism[i]);
    end
    err_sum = {1'b0, err_cnt} + (CNT_WIDTH+1)'(n_mism);
  end

  assign rtr.wr   = wr_c;
  assign rtr.rd   = rd_c;
  assign rtr.data = data_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      timeout <= '0;
      err_ch  <= '0;
      err_cnt <= '0;
      nw_q    <= '0;
      en_q    <= '0;
      rd_d    <= '0;
      // NOTE: these per-channel arrays are plain flops, not RAM, so they take the reset too.
      for (int i = 0; i < N_CH; i++) begin
        gen_lfsr[i] <= seed_of(i);
        exp_lfsr[i] <= seed_of(i);
        sent[i]     <= '0;
        issued[i]   <= '0;
        recv[i]     <= '0;
        idle_cnt[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking throughout so each channel sees pre-edge values regardless of loop order.
      done <= 1'b0;
      rd_d <= rd_c;

      // Compares are not gated by state: a read in flight when a channel times out is still checked.
      for (int i = 0; i < N_CH; i++) begin
        if (rd_d[i]) begin
          exp_lfsr[i] <= lfsr_step(exp_lfsr[i]);
          recv[i]     <= recv[i] + 1'b1;
        end
        if (wr_c[i]) begin
          gen_lfsr[i] <= lfsr_step(gen_lfsr[i]);
          sent[i]     <= sent[i] + 1'b1;
        end
        if (rd_c[i]) issued[i] <= issued[i] + 1'b1;

        if (wr_c[i] | rd_d[i]) begin
          idle_cnt[i] <= '0;
        end else if ((state == RUN) && en_q[i] && !ch_fin[i]) begin
          idle_cnt[i] <= idle_cnt[i] + 1'b1;
          if (idle_cnt[i] == IDLE_W'(TIMEOUT - 1)) timeout[i] <= 1'b1;
        end
      end

      if (|mism) begin
        err_ch  <= err_ch | mism;
        err_cnt <= err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
      end

      unique case (state)
        IDLE: if (start) begin
          state   <= RUN;
          busy    <= 1'b1;
          nw_q    <= num_words;
          en_q    <= ch_en;
          pass    <= 1'b0;
          timeout <= '0;
          err_ch  <= '0;
          err_cnt <= '0;
          rd_d    <= '0;
          for (int i = 0; i < N_CH; i++) begin
            gen_lfsr[i] <= seed_of(i);
            exp_lfsr[i] <= seed_of(i);
            sent[i]     <= '0;
            issued[i]   <= '0;
            recv[i]     <= '0;
            idle_cnt[i] <= '0;
          end
        end
        RUN: if (&ch_fin) begin
          state <= FINISH;
          done  <= 1'b1;
          pass  <= (err_cnt == '0) && (timeout == '0);
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_router_traffic_checker.sv
// Bench for router_traffic_checker: depth-8 loopback FIFO model per channel with
// random back-pressure, fault injection, and a reference LFSR stream per channel.
`timescale 1ns/100ps
module tb_router_traffic_checker;
  localparam int          DW   = 8;
  localparam int          NC   = 4;
  localparam int          CW   = 16;
  localparam int          TO   = 1024;
  localparam logic [31:0] SEED = 32'h0000_0001;
  localparam int          DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_words = '0;
  logic [NC-1:0] ch_en = '0;
  logic          busy, done, pass;
  logic [NC-1:0] timeout, err_ch;
  logic [CW-1:0] err_cnt;

  router_traffic_checker_if #(.N_CH(NC), .DATA_WIDTH(DW)) rtr ();

  router_traffic_checker #(
    .DATA_WIDTH(DW), .N_CH(NC), .CNT_WIDTH(CW), .TIMEOUT(TO), .SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words), .ch_en(ch_en),
    .rtr(rtr), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_ch(err_ch), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference stream straight from the LFSR definition.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [31:0] seed_of(input int c);
    logic [31:0] s;
    s = SEED + 32'(c);
    return (s == 0) ? 32'd1 : s;
  endfunction

  // Test-controlled knobs (written only by the stimulus thread).
  bit          bp = 1'b0;
  logic [NC-1:0] stuck_full = '0;
  int          corrupt_ch = -1;
  int          corrupt_idx = -1;

  // Model state (written only by the model thread).
  logic [DW-1:0] fifo [NC][$];
  logic [31:0]   exp_lfsr [NC];
  int            n_wr [NC];
  int            n_rd [NC];
  int            n_wr_bad [NC];
  int            n_underflow = 0;
  int            done_cnt = 0;
  int            cyc = 0;
  int            run_cyc = 0;
  int            done_cyc = 0;
  int            to1_cyc = -1;
  bit            pass_at_done = 1'b0;
  bit            busy_prev = 1'b0;

  logic [NC-1:0]    cap_wr, cap_rd;
  logic [NC*DW-1:0] cap_data;
  bit               cap_start;

  // Router model: strobes are sampled at the negedge (stable until the next
  // posedge commits them), the FIFO is updated just after that posedge.
  always begin
    @(negedge clk);
    cyc++;
    cap_wr    = rtr.wr;
    cap_rd    = rtr.rd;
    cap_data  = rtr.data;
    cap_start = start && !busy && rst_n;
    if (busy && !busy_prev) run_cyc = cyc;
    busy_prev = busy;
    if (timeout[1] && to1_cyc < 0) to1_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      pass_at_done = pass;
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      for (int c = 0; c < NC; c++) fifo[c].delete();
      rtr.q = '0;
    end else begin
      if (cap_start) begin
        done_cnt    = 0;
        to1_cyc     = -1;
        n_underflow = 0;
        for (int c = 0; c < NC; c++) begin
          exp_lfsr[c] = seed_of(c);
          n_wr[c] = 0; n_rd[c] = 0; n_wr_bad[c] = 0;
        end
      end
      for (int c = 0; c < NC; c++) begin
        if (cap_rd[c]) begin
          if (fifo[c].size() == 0) n_underflow++;
          else rtr.q[c*DW +: DW] = fifo[c].pop_front();
          n_rd[c]++;
        end
        if (cap_wr[c]) begin
          logic [DW-1:0] w;
          w = cap_data[c*DW +: DW];
          if (w != exp_lfsr[c][DW-1:0]) n_wr_bad[c]++;
          exp_lfsr[c] = lfsr_next(exp_lfsr[c]);
          if (c == corrupt_ch && n_wr[c] == corrupt_idx) w[0] = ~w[0];
          if (fifo[c].size() < DEPTH) fifo[c].push_back(w);
          n_wr[c]++;
        end
      end
    end
    for (int c = 0; c < NC; c++) begin
      rtr.full[c] = (fifo[c].size() >= DEPTH) || stuck_full[c] || (bp && $urandom_range(3) == 0);
      rtr.mty[c]  = (fifo[c].size() == 0) || (bp && $urandom_range(3) == 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic run_start(input logic [CW-1:0] nw, input logic [NC-1:0] en);
    num_words = nw;
    ch_en     = en;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for done within budget; optionally pulses start again at cycle mid.
  task automatic run_wait(input int budget, input int mid);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      tick();
      start = (i == mid);
    end
    start = 1'b0;
    repeat (4) tick();
    check("done_once", done_cnt, 1);
  endtask

  task automatic check_counts(input int nw, input logic [NC-1:0] en);
    for (int c = 0; c < NC; c++) begin
      check($sformatf("wr_cnt_ch%0d", c), n_wr[c], en[c] ? nw : 0);
      check($sformatf("rd_cnt_ch%0d", c), n_rd[c], en[c] ? nw : 0);
      check($sformatf("wr_data_ch%0d", c), n_wr_bad[c], 0);
    end
    check("underflow", n_underflow, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_timeout", timeout, 0);
    check("rst_err_ch", err_ch, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_wr", rtr.wr, 0);
    check("rst_rd", rtr.rd, 0);
    check("rst_data", rtr.data, 0);
    rst_n = 1'b1;
    tick();

    // Clean loopback, all channels
    run_start(100, 4'b1111);
    run_wait(2000, -1);
    check("t1_pass_at_done", pass_at_done, 1);
    check("t1_err_cnt", err_cnt, 0);
    check("t1_err_ch", err_ch, 0);
    check("t1_timeout", timeout, 0);
    check_counts(100, 4'b1111);
    repeat (5) tick();
    check("t1_pass_held", pass, 1);
    check("t1_busy_after", busy, 0);

    // Corrupt word 17 of channel 2
    corrupt_ch = 2; corrupt_idx = 17;
    run_start(100, 4'b1111);
    run_wait(2000, -1);
    corrupt_ch = -1; corrupt_idx = -1;
    check("t2_pass_at_done", pass_at_done, 0);
    check("t2_err_ch", err_ch, 4'b0100);
    check("t2_err_cnt", err_cnt, 1);
    check("t2_timeout", timeout, 0);
    check_counts(100, 4'b1111);

    // Channel 1 full stuck high -> timeout exactly TO cycles after RUN entry
    stuck_full = 4'b0010;
    run_start(100, 4'b0011);
    run_wait(3000, -1);
    stuck_full = '0;
    check("t3_timeout", timeout, 4'b0010);
    check("t3_pass_at_done", pass_at_done, 0);
    check("t3_err_cnt", err_cnt, 0);
    check("t3_to_latency", to1_cyc - run_cyc, TO);
    check("t3_ch0_wr", n_wr[0], 100);
    check("t3_ch0_rd", n_rd[0], 100);
    check("t3_ch0_data", n_wr_bad[0], 0);
    check("t3_ch1_wr", n_wr[1], 0);

    // Zero words: one RUN cycle then FINISH
    run_start(0, 4'b0101);
    run_wait(50, -1);
    check("t4_pass_at_done", pass_at_done, 1);
    check("t4_done_latency", done_cyc - run_cyc, 1);
    check_counts(0, 4'b0101);

    // Random back-pressure, second start mid-run is ignored
    bp = 1'b1;
    run_start(500, 4'b1111);
    run_wait(8000, 50);
    bp = 1'b0;
    check("t5_pass_at_done", pass_at_done, 1);
    check("t5_err_cnt", err_cnt, 0);
    check("t5_timeout", timeout, 0);
    check_counts(500, 4'b1111);

    // Reset mid-run, then a fresh short run
    bp = 1'b1;
    run_start(500, 4'b1111);
    repeat (200) tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_pass", pass, 0);
    check("t6_rst_wr", rtr.wr, 0);
    check("t6_rst_rd", rtr.rd, 0);
    check("t6_rst_data", rtr.data, 0);
    check("t6_rst_err_cnt", err_cnt, 0);
    repeat (3) tick();
    check("t6_no_done", done_cnt, 0);
    rst_n = 1'b1;
    bp = 1'b0;
    tick();
    run_start(10, 4'b1111);
    run_wait(500, -1);
    check("t6_pass_at_done", pass_at_done, 1);
    check("t6_err_cnt", err_cnt, 0);
    check_counts(10, 4'b1111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/router_traffic_checker.md
Name: router_traffic_checker

Overview:
- Synthesisable, multi-channel successor to the simulation-only router tester.
- Drives N_CH independent FIFO-style write ports into the router with LFSR pseudo-random data.
- Reads each corresponding output port back, compares against a locally regenerated expected stream, and reports per-channel mismatches, timeouts and overall pass/fail.
- Sits beside the router in the self-test wrapper; it is started and inspected from the control block.

Parameters:
- DATA_WIDTH, 8, payload width per channel; legal range 1..32.
- N_CH, 4, number of independent channels (write port i loops back to read port i).
- CNT_WIDTH, 16, width of word-count and error counters.
- TIMEOUT, 1024, cycles without progress on a channel before it is declared timed out.
- SEED, 32'h0000_0001, base LFSR seed; channel i uses SEED+i, and a zero result is forced to 1.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- num_words  in  CNT_WIDTH  words per enabled channel; sampled on start.
- ch_en  in  N_CH  channel enable mask; sampled on start.
- wr  out  N_CH  write strobe to the router input FIFO, per channel.
- data  out  N_CH*DATA_WIDTH  write data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- full  in  N_CH  router input FIFO full, per channel.
- rd  out  N_CH  read strobe to the router output FIFO, per channel.
- q  in  N_CH*DATA_WIDTH  read data, same packing as data; valid one cycle after rd.
- mty  in  N_CH  router output FIFO empty, per channel.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at run end.
- pass  out  1  result of the last run; held until the next start.
- timeout  out  N_CH  sticky per-channel timeout flags; cleared on start.
- err_ch  out  N_CH  sticky per-channel mismatch flags; cleared on start.
- err_cnt  out  CNT_WIDTH  total mismatches across all channels; saturating; cleared on start.

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE. busy=0, done=0, pass=0, timeout=0, err_ch=0, err_cnt=0, wr=0, rd=0, data=0. All counters cleared and LFSRs loaded with seeds. Reset mid-run aborts immediately with no done pulse.
- FSM states: IDLE, RUN, FINISH.
  - IDLE->RUN on start=1: latch num_words/ch_en, reload all gen and exp LFSRs, clear counters and sticky flags, set pass=0.
  - start while in RUN or FINISH is ignored.
  - RUN->FINISH when every channel is finished. A channel is finished if it is disabled, has received num_words words, or has timed out.
  - FINISH->IDLE after one cycle. In FINISH, done=1 and pass=(err_cnt==0 && timeout==0).
- LFSR: 32-bit Fibonacci, taps 32,22,2,1, shift-left, feedback into bit0. Each channel has one generator LFSR and one expected LFSR with the same seed. data/compare value = LFSR[DATA_WIDTH-1:0].
- Write side, channel i (combinational strobe):
  - wr[i] = RUN & en[i] & ~full[i] & (sent_i < num_words) & ~timeout[i].
  - data[i] = gen LFSR value. On a cycle with wr[i]=1: gen LFSR steps, sent_i increments.
  - Back-to-back writes are allowed.
- Read side, channel i:
  - rd[i] = RUN & en[i] & ~mty[i] & (issued_i < num_words) & ~timeout[i]; issued_i increments on rd.
  - rd_d[i] is rd[i] registered. When rd_d[i]=1: compare q[i] with the exp LFSR value, step the exp LFSR, increment recv_i.
  - On mismatch: set err_ch[i]; err_cnt += 1, saturating at all-ones.
  - Simultaneous mismatches on k channels in one cycle add k, still saturating.
  - Back-to-back reads are allowed, one compare per cycle.
- Timeout, per channel:
  - Idle counter clears on wr[i] or rd_d[i]; otherwise increments while the channel is enabled, in RUN and not finished.
  - When the counter reaches TIMEOUT: set timeout[i]; the channel stops issuing wr/rd.
  - A read already in flight (rd_d) is still compared.
- Boundaries:
  - num_words=0 or ch_en=0: RUN lasts one cycle, then FINISH with pass=1.
  - full stuck high: timeout fires exactly TIMEOUT cycles after the last progress.
  - Counters never exceed num_words; sent/issued stop at num_words.
  - busy=1 in RUN and FINISH.

Test Plan:
- Loopback model (ideal depth-8 FIFO per channel), ch_en=4'b1111, num_words=100 -> 100 writes and 100 reads per channel, done pulses once, pass=1, err_cnt=0, timeout=0.
- Same setup, model corrupts word 17 of channel 2 (bit0 flipped) -> err_ch=4'b0100, err_cnt=1, pass=0.
- Channel 1 full tied high, TIMEOUT=1024, ch_en=4'b0011 -> timeout=4'b0010; done asserts; channel 0 completes normally; pass=0.
- ch_en=4'b0101, num_words=0 -> wr/rd never asserted, done one cycle after RUN entry, pass=1.
- Random full/mty back-pressure, num_words=500, plus a second start pulse mid-run -> second start ignored, pass=1, exactly 500 writes per channel.
- rst_n dropped mid-run, then a fresh start with num_words=10 -> outputs at reset values during reset, no done pulse from the aborted run, new run passes with LFSR restarting at seed values.
